// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
package if_pkg;
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_e;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int PC_INC = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// pc_reg: program counter with redirect mux, +4 incrementer and advance enable.
module pc_reg
    import if_pkg::*;
#(
    parameter int PC_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv_i,
    input  logic            redir_i,
    input  logic [PC_W-1:0] redir_addr_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_inc_o
);
    logic [PC_W-1:0] pc_q, pc_d;
    assign pc_o = pc_q;
    assign pc_inc_o = pc_q + PC_W'(PC_INC);
    always_comb pc_d = redir_i ? (redir_addr_i & ~PC_W'(3)) : adv_i ? pc_inc_o : pc_q;
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC & ~PC_W'(3);
        else pc_q <= pc_d;
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: single-outstanding instruction fetch with freeze/flush and IF/ID register.
// Optional perf counters enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int PC_W = 32,
    parameter int INSTR_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Freeze,
    input  logic               Branch_taken,
    input  logic [PC_W-1:0]    Branch_addr,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt,
    output logic [15:0]        perf_drop_cnt,
`endif
    output logic [PC_W-1:0]    PC_out,
    output logic [INSTR_W-1:0] Instruction,
    output logic               Valid
);
    state_e state_q, state_d;
    logic discard_q, discard_d;
    logic [INSTR_W-1:0] hold_q, hold_d, ld_ins;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d, pc, pc_inc;
    logic [INSTR_W-1:0] ifid_ins_q, ifid_ins_d;
    logic ifid_v_q, ifid_v_d, load, keep;

    pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .adv_i(load), .redir_i(Branch_taken),
        .redir_addr_i(Branch_addr), .pc_o(pc), .pc_inc_o(pc_inc)
    );

    assign imem_req = state_q == REQ;
    assign imem_addr = pc;
    assign PC_out = ifid_pc_q;
    assign Instruction = ifid_ins_q;
    assign Valid = ifid_v_q;

    always_comb begin
        state_d = state_q;
        discard_d = discard_q;
        hold_d = hold_q;
        load = 1'b0;
        ld_ins = imem_rdata;
        unique case (state_q)
            REQ: begin
                // a request accepted together with a redirect fetched the old PC
                if (imem_ready) begin
                    state_d = WAIT;
                    discard_d = Branch_taken;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    discard_d = 1'b0;
                    hold_d = imem_rdata;
                    load = !discard_q && !Branch_taken && !Freeze;
                    state_d = (discard_q || Branch_taken || !Freeze) ? REQ : HOLD;
                end else if (Branch_taken) discard_d = 1'b1;
            end
            HOLD: begin
                ld_ins = hold_q;
                load = !Branch_taken && !Freeze;
                state_d = (Branch_taken || !Freeze) ? REQ : HOLD;
            end
            default: state_d = REQ;
        endcase
        // without a load or a freeze the register takes a bubble
        keep = Freeze && !Branch_taken;
        ifid_v_d = load || (keep && ifid_v_q);
        ifid_pc_d = load ? pc_inc : keep ? ifid_pc_q : '0;
        ifid_ins_d = load ? ld_ins : keep ? ifid_ins_q : INSTR_W'(NOP_INSTR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            discard_q <= 1'b0;
            hold_q <= '0;
            ifid_pc_q <= '0;
            ifid_ins_q <= '0;
            ifid_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            discard_q <= discard_d;
            hold_q <= hold_d;
            ifid_pc_q <= ifid_pc_d;
            ifid_ins_q <= ifid_ins_d;
            ifid_v_q <= ifid_v_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic drop;
    logic [31:0] fetch_q, stall_q;
    logic [15:0] drop_q;
    assign drop = (state_q == WAIT && imem_rvalid && (discard_q || Branch_taken)) ||
                  (state_q == HOLD && Branch_taken);
    assign perf_fetch_cnt = fetch_q;
    assign perf_stall_cnt = stall_q;
    assign perf_drop_cnt = drop_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= '0;
            stall_q <= '0;
            drop_q <= '0;
        end else begin
            fetch_q <= fetch_q + 32'(load);
            stall_q <= stall_q + 32'(Freeze && ifid_v_q);
            drop_q <= drop_q + 16'(drop);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus random traffic checked against a
// transaction-level model of fetch, freeze and flush.
module tb_if_fetch_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic Freeze = 1'b0, Branch_taken = 1'b0, imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] Branch_addr = '0, imem_rdata = '0;
    logic imem_req, Valid;
    logic [31:0] imem_addr, PC_out, Instruction;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
    logic [15:0] perf_drop_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .Freeze(Freeze), .Branch_taken(Branch_taken),
        .Branch_addr(Branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
        .perf_drop_cnt(perf_drop_cnt),
`endif
        .PC_out(PC_out), .Instruction(Instruction), .Valid(Valid)
    );

    int total = 0, bad = 0;
    // model: expected fetch PC, one outstanding request, an undelivered response, IF/ID contents
    logic [31:0] m_pc, m_opc, m_ppc, m_pins, m_ifpc, m_ifins;
    bit m_out, m_kill, m_pend, m_ifv;
    int unsigned m_fetch, m_stall, m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_opc = '0; m_ppc = '0; m_pins = '0; m_ifpc = '0; m_ifins = '0;
        m_out = 0; m_kill = 0; m_pend = 0; m_ifv = 0;
        m_fetch = 0; m_stall = 0; m_drop = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; Freeze = 0; Branch_taken = 0; imem_ready = 0; imem_rvalid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
    endtask

    task automatic cyc(input bit fr, input bit br, input logic [31:0] ba,
                       input bit rdy, input bit rv, input logic [31:0] rd);
        bit acc, nv;
        logic [31:0] npc, nins;
        Freeze = fr; Branch_taken = br; Branch_addr = ba;
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        @(negedge clk);
        chk("valid", Valid, m_ifv);
        chk("pc_out", PC_out, m_ifpc);
        chk("instr", Instruction, m_ifins);
        chk("req", imem_req, !(m_out || m_pend));
        if (!(m_out || m_pend)) chk("addr", imem_addr, m_pc);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_stall", perf_stall_cnt, m_stall);
        chk("perf_drop", {16'h0, perf_drop_cnt}, m_drop & 32'hFFFF);
`endif
        acc = rdy && !(m_out || m_pend);
        nv = fr && !br && m_ifv;
        npc = (fr && !br) ? m_ifpc : 32'h0;
        nins = (fr && !br) ? m_ifins : 32'h0;
        if (fr && m_ifv) m_stall++;
        if (m_pend && br) m_drop++;
        if (m_out && rv) begin
            m_out = 0;
            if (m_kill || br) m_drop++;
            else begin
                m_pend = 1; m_ppc = m_opc + 32'd4; m_pins = rd;
            end
            m_kill = 0;
        end
        if (acc) begin
            m_out = 1; m_opc = m_pc; m_kill = br;
        end else if (br && m_out) m_kill = 1;
        if (br) begin
            m_pend = 0; m_pc = ba & ~32'd3;
        end else if (m_pend && !fr) begin
            nv = 1; npc = m_ppc; nins = m_pins; m_pc = m_ppc; m_pend = 0; m_fetch++;
        end
        m_ifv = nv; m_ifpc = npc; m_ifins = nins;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit rdy, rv;
        m_reset();
        do_reset();
        chk("rst_valid", Valid, 1'b0);
        chk("rst_pc_out", PC_out, 32'h0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_req", imem_req, 1'b1);
        chk("rst_addr", imem_addr, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("late_rvalid_valid", Valid, 1'b0);
        // back-to-back fetches
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hAAAA_0001);
        chk("s1_pc_a", PC_out, 32'h4); chk("s1_ins_a", Instruction, 32'hAAAA_0001);
        chk("s1_addr_4", imem_addr, 32'h4);
        cyc(0, 0, 0, 1, 0, 0);
        chk("s1_bubble", Valid, 1'b0);
        cyc(0, 0, 0, 0, 1, 32'hBBBB_0002);
        chk("s1_pc_b", PC_out, 32'h8); chk("s1_ins_b", Instruction, 32'hBBBB_0002);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hCCCC_0003);
        chk("s1_pc_c", PC_out, 32'hC); chk("s1_ins_c", Instruction, 32'hCCCC_0003);
        // freeze while a response arrives
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h1111_0004);
        cyc(1, 0, 0, 1, 0, 0);
        chk("s2_hold1", PC_out, 32'h10);
        cyc(1, 0, 0, 0, 1, 32'h2222_0005);
        chk("s2_hold2", PC_out, 32'h10); chk("s2_hold_ins", Instruction, 32'h1111_0004);
        chk("s2_noreq", imem_req, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("s2_hold3", Valid, 1'b1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("s2_pc_b", PC_out, 32'h14); chk("s2_ins_b", Instruction, 32'h2222_0005);
        chk("s2_addr", imem_addr, 32'h14);
        // branch in WAIT, response arrives later
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 32'h100, 0, 0, 0);
        chk("s3_flush", Valid, 1'b0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hBAD0_0006);
        chk("s3_drop_valid", Valid, 1'b0); chk("s3_addr", imem_addr, 32'h100);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h3333_0007);
        chk("s3_pc", PC_out, 32'h104);
        // branch + response + freeze in the same cycle
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 1, 32'h203, 0, 1, 32'hBAD0_0008);
        chk("s4_valid", Valid, 1'b0); chk("s4_ins", Instruction, 32'h0);
        chk("s4_addr", imem_addr, 32'h200);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h4444_0009);
        chk("s4_pc", PC_out, 32'h204); chk("s4_ins2", Instruction, 32'h4444_0009);
        // memory not ready, redirect while the request waits
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("s5_addr_old", imem_addr, 32'h204);
        cyc(0, 1, 32'h300, 0, 0, 0);
        chk("s5_req", imem_req, 1'b1); chk("s5_addr_new", imem_addr, 32'h300);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h5555_000A);
        chk("s5_pc", PC_out, 32'h304);
        // PC wrap
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h6666_000B);
        chk("s6_pc_wrap", PC_out, 32'h0); chk("s6_ins", Instruction, 32'h6666_000B);
        chk("s6_addr", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("s6_fetch_total", perf_fetch_cnt, 32'd9);
        chk("s6_stall_total", perf_stall_cnt, 32'd3);
        chk("s6_drop_total", {16'h0, perf_drop_cnt}, 32'd2);
`endif
        // random traffic with occasional mid-transaction reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 250 == 0) begin
                do_reset();
                cyc(0, 0, 0, 0, 1, $urandom);
            end else begin
                rdy = ($urandom % 4) != 0;
                rv = m_out && ($urandom % 3 == 0);
                cyc(($urandom % 4) == 0, ($urandom % 10) == 0,
                    ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom,
                    rdy, rv, $urandom);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
